// File: rtl/lcd_win_pkg.sv
// Shared definitions for the parametrised LCD window controller:
// command codes, controller states and coordinate-width helper.
package lcd_win_pkg;

    localparam logic [2:0] CMD_REFLASH = 3'd0;
    localparam logic [2:0] CMD_LOAD    = 3'd1;
    localparam logic [2:0] CMD_RIGHT   = 3'd2;
    localparam logic [2:0] CMD_LEFT    = 3'd3;
    localparam logic [2:0] CMD_UP      = 3'd4;
    localparam logic [2:0] CMD_DOWN    = 3'd5;
    localparam logic [2:0] CMD_AVERAGE = 3'd6;
    localparam logic [2:0] CMD_MIRRORX = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CALC,
        ST_ACC,
        ST_WRITE,
        ST_DISP
    } state_e;

    // Bits needed to hold any value in 0..n-1 (at least one bit).
    function automatic int unsigned coord_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lcd_win_addr_gen.sv
// Window raster counter: walks a WIN x WIN window row-major from (x0,y0)
// and presents the linear image address of the current pixel.
module lcd_win_addr_gen
    import lcd_win_pkg::*;
#(
    parameter int unsigned IMG_W = 6,
    parameter int unsigned IMG_H = 6,
    parameter int unsigned WIN   = 3
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [coord_w(IMG_W)-1:0]           x0,
    input  logic [coord_w(IMG_H)-1:0]           y0,
    output logic [coord_w(IMG_W*IMG_H)-1:0]     addr,
    output logic                                run,
    output logic                                done
);

    localparam int unsigned AW = coord_w(IMG_W * IMG_H);
    localparam int unsigned CW = coord_w(WIN);

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic          run_q, run_d;
    logic [AW-1:0] row_abs;
    logic [AW-1:0] col_abs;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        run_d = run_q;
        if (start) begin
            col_d = '0;
            row_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            if (col_q == CW'(WIN - 1)) begin
                col_d = '0;
                if (row_q == CW'(WIN - 1)) begin
                    run_d = 1'b0;
                end else begin
                    row_d = row_q + CW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            col_q <= '0;
            row_q <= '0;
            run_q <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            run_q <= run_d;
        end
    end

    always_comb begin
        row_abs = AW'(y0) + AW'(row_q);
        col_abs = AW'(x0) + AW'(col_q);
        addr    = row_abs * AW'(IMG_W) + col_abs;
    end

    assign run  = run_q;
    assign done = run_q && (col_q == CW'(WIN - 1)) && (row_q == CW'(WIN - 1));

endmodule

// File: rtl/lcd_win_ctrl.sv
// LCD window controller: holds an IMG_W x IMG_H image, executes one command
// at a time and streams the current WIN x WIN window to the pixel driver.
module lcd_win_ctrl
    import lcd_win_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned IMG_W = 6,
    parameter int unsigned IMG_H = 6,
    parameter int unsigned WIN   = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] datain,
    input  logic [2:0]    cmd,
    input  logic          cmd_valid,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          busy
);

    localparam int unsigned NPIX = IMG_W * IMG_H;
    localparam int unsigned NWIN = WIN * WIN;
    localparam int unsigned XW   = coord_w(IMG_W);
    localparam int unsigned YW   = coord_w(IMG_H);
    localparam int unsigned AW   = coord_w(NPIX);
    localparam int unsigned ACCW = DW + $clog2(NWIN);

    localparam logic [XW-1:0] X_C   = XW'((IMG_W - WIN) / 2);
    localparam logic [YW-1:0] Y_C   = YW'((IMG_H - WIN) / 2);
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - WIN);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - WIN);

    state_e          state_q, state_d;
    logic [2:0]      cmd_q, cmd_d;
    logic [XW-1:0]   x0_q, x0_d;
    logic [YW-1:0]   y0_q, y0_d;
    logic [AW-1:0]   ld_cnt_q, ld_cnt_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [DW-1:0]   pix_q, pix_d;
    logic            pix_vld_q, pix_vld_d;
    logic            pix_last_q, pix_last_d;
    logic            busy_q, busy_d;
    logic            output_valid_q, output_valid_d;
    logic [DW-1:0]   dataout_q, dataout_d;

    logic [DW-1:0]   mem_q [NPIX];
    logic [DW-1:0]   mem_d [NPIX];

    logic            accept;
    logic            gen_start;
    logic [AW-1:0]   gen_addr;
    logic            gen_run;
    logic            gen_done;
    logic [DW-1:0]   avg;

    function automatic logic [AW-1:0] pix_addr(input int unsigned x, input int unsigned y);
        return AW'(y * IMG_W + x);
    endfunction

    assign accept    = cmd_valid && !busy_q && (state_q == ST_IDLE);
    assign gen_start = ((state_d == ST_ACC) || (state_d == ST_DISP)) && (state_d != state_q);
    assign avg       = DW'(acc_q / ACCW'(NWIN));

    lcd_win_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .WIN   (WIN)
    ) u_addr_gen (
        .clk   (clk),
        .reset (reset),
        .start (gen_start),
        .x0    (x0_q),
        .y0    (y0_q),
        .addr  (gen_addr),
        .run   (gen_run),
        .done  (gen_done)
    );

    always_comb begin
        state_d        = state_q;
        cmd_d          = cmd_q;
        x0_d           = x0_q;
        y0_d           = y0_q;
        ld_cnt_d       = ld_cnt_q;
        acc_d          = acc_q;
        pix_d          = pix_q;
        pix_vld_d      = 1'b0;
        pix_last_d     = 1'b0;
        output_valid_d = 1'b0;
        dataout_d      = dataout_q;
        busy_d         = (state_q != ST_IDLE);
        mem_d          = mem_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cmd_d = cmd;
                    case (cmd)
                        CMD_LOAD: begin
                            state_d  = ST_LOAD;
                            ld_cnt_d = '0;
                        end
                        CMD_AVERAGE: begin
                            state_d = ST_ACC;
                            acc_d   = '0;
                        end
                        default: state_d = ST_CALC;
                    endcase
                end
            end
            ST_LOAD: begin
                mem_d[ld_cnt_q] = datain;
                if (ld_cnt_q == AW'(NPIX - 1)) begin
                    state_d = ST_DISP;
                    x0_d    = X_C;
                    y0_d    = Y_C;
                end else begin
                    ld_cnt_d = ld_cnt_q + AW'(1);
                end
            end
            ST_CALC: begin
                case (cmd_q)
                    CMD_RIGHT: if (x0_q != X_MAX) x0_d = x0_q + XW'(1);
                    CMD_LEFT:  if (x0_q != '0)    x0_d = x0_q - XW'(1);
                    CMD_DOWN:  if (y0_q != Y_MAX) y0_d = y0_q + YW'(1);
                    CMD_UP:    if (y0_q != '0)    y0_d = y0_q - YW'(1);
                    CMD_MIRRORX: begin
                        for (int unsigned r = 0; r < WIN; r++) begin
                            for (int unsigned i = 0; i < WIN; i++) begin
                                mem_d[pix_addr(32'(x0_q) + i, 32'(y0_q) + r)] =
                                    mem_q[pix_addr(32'(x0_q) + WIN - 1 - i, 32'(y0_q) + r)];
                            end
                        end
                    end
                    default: ;
                endcase
                state_d = ST_DISP;
            end
            ST_ACC: begin
                // Registered read: the sum trails the raster by one cycle.
                if (gen_run) begin
                    pix_d      = mem_q[gen_addr];
                    pix_vld_d  = 1'b1;
                    pix_last_d = gen_done;
                end
                if (pix_vld_q) begin
                    acc_d = acc_q + ACCW'(pix_q);
                end
                if (pix_last_q) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                for (int unsigned r = 0; r < WIN; r++) begin
                    for (int unsigned i = 0; i < WIN; i++) begin
                        mem_d[pix_addr(32'(x0_q) + i, 32'(y0_q) + r)] = avg;
                    end
                end
                state_d = ST_DISP;
            end
            ST_DISP: begin
                if (gen_run) begin
                    dataout_d      = mem_q[gen_addr];
                    output_valid_d = 1'b1;
                    if (gen_done) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            cmd_q          <= '0;
            x0_q           <= X_C;
            y0_q           <= Y_C;
            ld_cnt_q       <= '0;
            acc_q          <= '0;
            pix_q          <= '0;
            pix_vld_q      <= 1'b0;
            pix_last_q     <= 1'b0;
            busy_q         <= 1'b0;
            output_valid_q <= 1'b0;
            dataout_q      <= '0;
        end else begin
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            x0_q           <= x0_d;
            y0_q           <= y0_d;
            ld_cnt_q       <= ld_cnt_d;
            acc_q          <= acc_d;
            pix_q          <= pix_d;
            pix_vld_q      <= pix_vld_d;
            pix_last_q     <= pix_last_d;
            busy_q         <= busy_d;
            output_valid_q <= output_valid_d;
            dataout_q      <= dataout_d;
        end
    end

    // Image storage survives reset; writes are only suppressed while it is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= mem_d;
        end
    end

    assign dataout      = dataout_q;
    assign output_valid = output_valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Directed bench for lcd_win_ctrl: default 6x6/3 instance plus an 8x5/4 instance.
module tb_lcd_win_ctrl;

    typedef int win9_t [9];

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din_a, dout_a, din_b, dout_b;
    logic [2:0] cmd_a, cmd_b;
    logic       cv_a, ov_a, busy_a, cv_b, ov_b, busy_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int first_a = -1;
    int busy_cnt_a = 0;
    int qa[$];
    int qb[$];

    win9_t e_ctr   = '{7, 8, 9, 13, 14, 15, 19, 20, 21};
    win9_t e_x2    = '{8, 9, 10, 14, 15, 16, 20, 21, 22};
    win9_t e_x3    = '{9, 10, 11, 15, 16, 17, 21, 22, 23};
    win9_t e_up    = '{3, 4, 5, 9, 10, 11, 15, 16, 17};
    win9_t e_avg   = '{14, 14, 14, 14, 14, 14, 14, 14, 14};
    win9_t e_edge  = '{6, 14, 14, 12, 14, 14, 18, 14, 14};
    win9_t e_mir   = '{9, 8, 7, 15, 14, 13, 21, 20, 19};
    win9_t e_rev   = '{28, 27, 26, 22, 21, 20, 16, 15, 14};

    lcd_win_ctrl #(.DW(8), .IMG_W(6), .IMG_H(6), .WIN(3)) u_dut_a (
        .clk          (clk),
        .reset        (reset),
        .datain       (din_a),
        .cmd          (cmd_a),
        .cmd_valid    (cv_a),
        .dataout      (dout_a),
        .output_valid (ov_a),
        .busy         (busy_a)
    );

    lcd_win_ctrl #(.DW(8), .IMG_W(8), .IMG_H(5), .WIN(4)) u_dut_b (
        .clk          (clk),
        .reset        (reset),
        .datain       (din_b),
        .cmd          (cmd_b),
        .cmd_valid    (cv_b),
        .dataout      (dout_b),
        .output_valid (ov_b),
        .busy         (busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ov_a) begin
            qa.push_back(int'(dout_a));
            if (first_a < 0) first_a = cyc;
        end
        if (busy_a) busy_cnt_a = busy_cnt_a + 1;
        if (ov_b) qb.push_back(int'(dout_b));
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_win(input string tag, input win9_t e);
        check_eq({tag, "_count"}, qa.size(), 9);
        for (int i = 0; i < 9; i++) begin
            check_eq($sformatf("%s_pix%0d", tag, i), (i < qa.size()) ? qa[i] : -1, e[i]);
        end
        qa.delete();
    endtask

    task automatic issue_a(input logic [2:0] c);
        @(negedge clk);
        qa.delete();
        first_a    = -1;
        busy_cnt_a = 0;
        cmd_a      = c;
        cv_a       = 1'b1;
        @(negedge clk);
        cv_a    = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_idle_a(input string tag);
        int k = 0;
        while (!busy_a && k < 20) begin
            @(negedge clk);
            k++;
        end
        while (busy_a && k < 500) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_idle"}, int'(busy_a), 0);
    endtask

    task automatic run_a(input logic [2:0] c, input string tag);
        issue_a(c);
        wait_idle_a(tag);
    endtask

    task automatic load_a(input int n, input bit rev);
        issue_a(3'd1);
        for (int i = 0; i < n; i++) begin
            din_a = 8'(rev ? 35 - i : i);
            @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        din_a = '0; cmd_a = '0; cv_a = 1'b0;
        din_b = '0; cmd_b = '0; cv_b = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", int'(busy_a), 0);
        check_eq("rst_valid", int'(ov_a), 0);
        check_eq("rst_dout", int'(dout_a), 0);
        reset = 1'b1;
        @(negedge clk);

        load_a(36, 1'b0);
        wait_idle_a("load");
        check_eq("load_latency", first_a - acc_cyc, 37);
        check_eq("load_busy_cycles", busy_cnt_a, 45);
        check_win("load", e_ctr);

        run_a(3'd2, "right1");
        check_eq("shift_latency", first_a - acc_cyc, 2);
        check_win("right1", e_x2);
        run_a(3'd2, "right2");
        check_win("right2", e_x3);
        run_a(3'd2, "right3_sat");
        check_win("right3_sat", e_x3);
        run_a(3'd4, "up1");
        check_win("up1", e_up);
        run_a(3'd4, "up2_sat");
        check_win("up2_sat", e_up);

        load_a(36, 1'b0);
        wait_idle_a("reload1");
        qa.delete();
        run_a(3'd6, "avg");
        check_eq("avg_latency", first_a - acc_cyc, 12);
        check_win("avg", e_avg);
        run_a(3'd0, "avg_reflash");
        check_win("avg_reflash", e_avg);
        run_a(3'd3, "avg_left");
        check_win("avg_left", e_edge);
        run_a(3'd0, "edge_reflash");
        check_win("edge_reflash", e_edge);

        load_a(36, 1'b0);
        wait_idle_a("reload2");
        qa.delete();
        run_a(3'd7, "mirror1");
        check_win("mirror1", e_mir);
        run_a(3'd7, "mirror2");
        check_win("mirror2", e_ctr);

        issue_a(3'd0);
        @(negedge clk);
        cmd_a = 3'd2;
        cv_a  = 1'b1;
        @(negedge clk);
        cv_a  = 1'b0;
        wait_idle_a("ignore");
        repeat (8) @(negedge clk);
        check_win("ignore", e_ctr);
        run_a(3'd0, "ignore_reflash");
        check_win("ignore_reflash", e_ctr);

        load_a(20, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", int'(busy_a), 0);
        check_eq("abort_valid", int'(ov_a), 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("abort_no_output", qa.size(), 0);
        load_a(36, 1'b1);
        wait_idle_a("reload3");
        check_win("reload3", e_rev);

        @(negedge clk);
        qb.delete();
        cmd_b = 3'd1;
        cv_b  = 1'b1;
        @(negedge clk);
        cv_b = 1'b0;
        for (int i = 0; i < 40; i++) begin
            din_b = 8'(i);
            @(negedge clk);
        end
        for (int k = 0; k < 100 && busy_b; k++) @(negedge clk);
        check_eq("sweep_idle", int'(busy_b), 0);
        check_eq("sweep_count", qb.size(), 16);
        check_eq("sweep_pix0", (qb.size() > 0) ? qb[0] : -1, 2);
        check_eq("sweep_pix1", (qb.size() > 1) ? qb[1] : -1, 3);
        check_eq("sweep_pix2", (qb.size() > 2) ? qb[2] : -1, 4);
        check_eq("sweep_pix3", (qb.size() > 3) ? qb[3] : -1, 5);
        check_eq("sweep_pix4", (qb.size() > 4) ? qb[4] : -1, 10);
        check_eq("sweep_pix15", (qb.size() > 15) ? qb[15] : -1, 29);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
